// File: rtl/pipeline_pkg.sv
// Shared definitions for the five-stage pipeline: instruction fields, opcodes,
// NOP encoding and hazard-controller state encoding.
package pipeline_pkg;

    localparam int INSTR_W = 20;
    localparam int OP_HI = 19, OP_LO = 16;
    localparam int RD_HI = 15, RD_LO = 12;
    localparam int RS_HI = 11, RS_LO = 8;
    localparam int RT_HI = 7,  RT_LO = 4;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_ADDI  = 4'd5;
    localparam logic [3:0] OP_LOAD  = 4'd6;
    localparam logic [3:0] OP_STORE = 4'd7;
    localparam logic [3:0] OP_BEQ   = 4'd8;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       reads_rs;
        logic       reads_rt;
        logic       writes_rd;
        logic       is_mem;
    } regs_used_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Instruction/status inputs and pipeline-register controls of the hazard controller.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16) ();
    import pipeline_pkg::*;

    logic [INSTR_W-1:0] instr_id;
    logic [INSTR_W-1:0] instr_ex;
    logic [INSTR_W-1:0] instr_mem;
    logic               branch_taken;
    logic               mem_busy;
    logic               pc_write;
    logic               if_id_write;
    logic               if_id_flush;
    logic               id_ex_bubble;
    logic               ex_mem_write;
    logic               mem_wb_bubble;
    logic [CNT_W-1:0]   stall_count;
    logic               mem_timeout;
    logic [1:0]         state;

    modport master (
        output instr_id, instr_ex, instr_mem, branch_taken, mem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
               ex_mem_write, mem_wb_bubble, stall_count, mem_timeout, state
    );

    modport slave (
        input  instr_id, instr_ex, instr_mem, branch_taken, mem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
               ex_mem_write, mem_wb_bubble, stall_count, mem_timeout, state
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_instr_regs_used.sv
// Decodes one instruction into its fields and register/memory usage flags.
module instr_regs_used
    import pipeline_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output regs_used_t         info
);

    always_comb begin
        info           = '0;
        info.op        = instr[OP_HI:OP_LO];
        info.rd        = instr[RD_HI:RD_LO];
        info.rs        = instr[RS_HI:RS_LO];
        info.rt        = instr[RT_HI:RT_LO];
        case (info.op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                info.reads_rs  = 1'b1;
                info.reads_rt  = 1'b1;
                info.writes_rd = 1'b1;
            end
            OP_ADDI: begin
                info.reads_rs  = 1'b1;
                info.writes_rd = 1'b1;
            end
            OP_LOAD: begin
                info.reads_rs  = 1'b1;
                info.writes_rd = 1'b1;
                info.is_mem    = 1'b1;
            end
            OP_STORE: begin
                info.reads_rs  = 1'b1;
                info.reads_rt  = 1'b1;
                info.is_mem    = 1'b1;
            end
            OP_BEQ: begin
                info.reads_rs  = 1'b1;
                info.reads_rt  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller: memory-busy freeze with timeout halt, branch flush,
// one-cycle load-use stall and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);

    localparam int STAGES = 3;
    localparam int WAIT_W = $clog2(MAX_WAIT + 2);

    logic [INSTR_W-1:0] instr [STAGES];
    regs_used_t         info  [STAGES];

    state_t             state_q;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   stall_cnt;
    logic               timeout_q;
    logic               halt, freeze, flush, load_use, stall_evt;

    // Index 0 = ID, 1 = EX, 2 = MEM.
    assign instr[0] = bus.instr_id;
    assign instr[1] = bus.instr_ex;
    assign instr[2] = bus.instr_mem;

    for (genvar g = 0; g < STAGES; g++) begin : g_dec
        instr_regs_used u_regs (.instr(instr[g]), .info(info[g]));
    end

    assign halt     = (state_q == ST_HALT);
    assign freeze   = bus.mem_busy && info[2].is_mem &&
                      (state_q == ST_RUN || state_q == ST_MEM_WAIT);
    assign flush    = (info[1].op == OP_BEQ) && bus.branch_taken;
    assign load_use = (info[1].op == OP_LOAD) && (info[1].rd != 4'd0) &&
                      ((info[0].reads_rs && info[0].rs == info[1].rd) ||
                       (info[0].reads_rt && info[0].rt == info[1].rd));
    assign stall_evt = halt || freeze || load_use;

    always_comb begin
        bus.pc_write      = 1'b1;
        bus.if_id_write   = 1'b1;
        bus.if_id_flush   = 1'b0;
        bus.id_ex_bubble  = 1'b0;
        bus.ex_mem_write  = 1'b1;
        bus.mem_wb_bubble = 1'b0;
        if (halt || freeze) begin
            // ID/EX holds its contents; only MEM/WB gets a bubble.
            bus.pc_write      = 1'b0;
            bus.if_id_write   = 1'b0;
            bus.ex_mem_write  = 1'b0;
            bus.mem_wb_bubble = 1'b1;
        end else if (flush) begin
            bus.if_id_flush  = 1'b1;
            bus.id_ex_bubble = 1'b1;
        end else if (load_use) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: if (freeze) begin
                    state_q  <= ST_MEM_WAIT;
                    wait_cnt <= WAIT_W'(1);
                end
                ST_MEM_WAIT: if (!freeze) begin
                    state_q  <= ST_RUN;
                    wait_cnt <= '0;
                end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                    state_q   <= ST_HALT;
                    timeout_q <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                ST_HALT: ;
                default: begin
                    state_q  <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall_evt && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign bus.stall_count = stall_cnt;
    assign bus.mem_timeout = timeout_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed checks of the hazard controller: vector table plus freeze/timeout,
// reset-in-HALT and counter saturation sequences.
module tb_pipeline_hazard_ctrl;
    import pipeline_pkg::*;

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_bubble}
    localparam logic [5:0] C_DEF = 6'b110010;
    localparam logic [5:0] C_FRZ = 6'b000001;
    localparam logic [5:0] C_FLS = 6'b111110;
    localparam logic [5:0] C_LU  = 6'b000110;

    typedef struct {
        logic [19:0] id, ex, mem;
        logic        bt, busy;
        logic [5:0]  ctl;
        logic        inc;
        logic [1:0]  st;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt;
    vec_t tv [16];

    always #5 clock = ~clock;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) bus  ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

    pipeline_hazard_ctrl #(.MAX_WAIT(15), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .bus(bus.slave));
    pipeline_hazard_ctrl #(.MAX_WAIT(15), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .bus(bus4.slave));

    function automatic logic [19:0] mk(input logic [3:0] op, rd, rs, rt);
        return {op, rd, rs, rt, 4'h0};
    endfunction

    function automatic logic [5:0] ctl1();
        return {bus.pc_write, bus.if_id_write, bus.if_id_flush,
                bus.id_ex_bubble, bus.ex_mem_write, bus.mem_wb_bubble};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [19:0] id, ex, mem, input logic bt, busy);
        bus.instr_id = id; bus.instr_ex = ex; bus.instr_mem = mem;
        bus.branch_taken = bt; bus.mem_busy = busy;
    endtask

    initial begin
        tv[0]  = '{20'h0, 20'h0, 20'h0, 1'b0, 1'b0, C_DEF, 1'b0, 2'd0};
        tv[1]  = '{mk(OP_ADD,1,3,2),  mk(OP_LOAD,3,1,0), 20'h0, 1'b0, 1'b0, C_LU,  1'b1, 2'd0};
        tv[2]  = '{mk(OP_ADD,1,3,2),  mk(OP_LOAD,0,1,0), 20'h0, 1'b0, 1'b0, C_DEF, 1'b0, 2'd0};
        tv[3]  = '{mk(OP_ADD,1,2,5),  mk(OP_LOAD,5,1,0), 20'h0, 1'b0, 1'b0, C_LU,  1'b1, 2'd0};
        tv[4]  = '{mk(OP_ADDI,1,2,5), mk(OP_LOAD,5,1,0), 20'h0, 1'b0, 1'b0, C_DEF, 1'b0, 2'd0};
        tv[5]  = '{mk(OP_STORE,0,2,5),mk(OP_LOAD,5,1,0), 20'h0, 1'b0, 1'b0, C_LU,  1'b1, 2'd0};
        tv[6]  = '{mk(OP_BEQ,0,5,2),  mk(OP_LOAD,5,1,0), 20'h0, 1'b0, 1'b0, C_LU,  1'b1, 2'd0};
        tv[7]  = '{mk(4'd9,0,5,5),    mk(OP_LOAD,5,1,0), 20'h0, 1'b0, 1'b0, C_DEF, 1'b0, 2'd0};
        tv[8]  = '{mk(OP_ADD,1,3,2),  mk(OP_ADD,3,1,2),  20'h0, 1'b0, 1'b0, C_DEF, 1'b0, 2'd0};
        tv[9]  = '{mk(OP_ADD,1,3,4),  mk(OP_BEQ,0,3,4),  20'h0, 1'b1, 1'b0, C_FLS, 1'b0, 2'd0};
        tv[10] = '{mk(OP_ADD,1,3,4),  mk(OP_BEQ,0,3,4),  20'h0, 1'b0, 1'b0, C_DEF, 1'b0, 2'd0};
        tv[11] = '{20'h0, mk(OP_BEQ,0,3,4), mk(OP_LOAD,2,1,0),  1'b1, 1'b1, C_FRZ, 1'b1, 2'd1};
        tv[12] = '{mk(OP_ADD,1,3,2), mk(OP_LOAD,3,1,0), mk(OP_LOAD,2,1,0), 1'b0, 1'b0, C_LU, 1'b1, 2'd0};
        tv[13] = '{20'h0, 20'h0, mk(OP_ADD,2,1,1),  1'b0, 1'b1, C_DEF, 1'b0, 2'd0};
        tv[14] = '{mk(OP_ADD,1,3,2), mk(OP_LOAD,3,1,0), mk(OP_STORE,0,1,2), 1'b0, 1'b1, C_FRZ, 1'b1, 2'd1};
        tv[15] = '{20'h0, 20'h0, 20'h0, 1'b0, 1'b0, C_DEF, 1'b0, 2'd0};

        reset = 1'b1;
        drive(NOP_INSTR, NOP_INSTR, NOP_INSTR, 1'b0, 1'b0);
        bus4.instr_id = NOP_INSTR; bus4.instr_ex = NOP_INSTR; bus4.instr_mem = NOP_INSTR;
        bus4.branch_taken = 1'b0; bus4.mem_busy = 1'b0;
        #12;
        chk("rst_state",   32'(bus.state), 0);
        chk("rst_count",   32'(bus.stall_count), 0);
        chk("rst_timeout", 32'(bus.mem_timeout), 0);
        chk("rst_ctl",     32'(ctl1()), 32'(C_DEF));
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        exp_cnt = 0;

        for (int i = 0; i < 16; i++) begin
            drive(tv[i].id, tv[i].ex, tv[i].mem, tv[i].bt, tv[i].busy);
            #1;
            chk($sformatf("vec%0d_ctl", i), 32'(ctl1()), 32'(tv[i].ctl));
            @(posedge clock); #1;
            exp_cnt += int'(tv[i].inc);
            chk($sformatf("vec%0d_state", i), 32'(bus.state), 32'(tv[i].st));
            chk($sformatf("vec%0d_count", i), 32'(bus.stall_count), 32'(exp_cnt));
        end

        // MAX_WAIT busy cycles: freeze throughout, then back to RUN without timeout.
        drive(NOP_INSTR, NOP_INSTR, mk(OP_STORE,0,1,2), 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            #1;
            chk($sformatf("wait%0d_ctl", i), 32'(ctl1()), 32'(C_FRZ));
            @(posedge clock); #1;
        end
        chk("wait_state_mw", 32'(bus.state), 32'(ST_MEM_WAIT));
        bus.mem_busy = 1'b0;
        #1;
        chk("wait_release_ctl", 32'(ctl1()), 32'(C_DEF));
        @(posedge clock); #1;
        exp_cnt += 15;
        chk("wait_state_run", 32'(bus.state), 32'(ST_RUN));
        chk("wait_timeout",   32'(bus.mem_timeout), 0);
        chk("wait_count",     32'(bus.stall_count), 32'(exp_cnt));

        // MAX_WAIT+1 busy cycles: HALT with sticky timeout.
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clock); #1;
            if (i == 14) begin
                chk("to_state_15", 32'(bus.state), 32'(ST_MEM_WAIT));
                chk("to_flag_15",  32'(bus.mem_timeout), 0);
            end
        end
        exp_cnt += 16;
        chk("to_state_halt", 32'(bus.state), 32'(ST_HALT));
        chk("to_flag",       32'(bus.mem_timeout), 1);
        bus.mem_busy = 1'b0;
        #1;
        chk("halt_ctl", 32'(ctl1()), 32'(C_FRZ));
        @(posedge clock); #1;
        exp_cnt += 1;
        chk("halt_stays",  32'(bus.state), 32'(ST_HALT));
        chk("halt_count",  32'(bus.stall_count), 32'(exp_cnt));

        // Asynchronous reset between edges.
        #2 reset = 1'b1;
        #1;
        chk("arst_state",   32'(bus.state), 32'(ST_RUN));
        chk("arst_count",   32'(bus.stall_count), 0);
        chk("arst_timeout", 32'(bus.mem_timeout), 0);
        chk("arst_ctl",     32'(ctl1()), 32'(C_DEF));
        #1 reset = 1'b0;

        // Saturation with a 4-bit counter: 20 load-use cycles hold at 15.
        @(posedge clock); #1;
        bus4.instr_ex = mk(OP_LOAD,3,1,0);
        bus4.instr_id = mk(OP_ADD,1,3,2);
        #1;
        chk("sat_ctl", 32'({bus4.pc_write, bus4.if_id_write, bus4.id_ex_bubble}), 32'(3'b001));
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (i == 13) chk("sat_count_14", 32'(bus4.stall_count), 14);
        end
        chk("sat_count", 32'(bus4.stall_count), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the 20-bit five-stage pipeline. It inspects the instructions held in the ID, EX and MEM stages and drives the write-enable, flush and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It freezes the pipeline while data memory is busy and halts it if a memory access times out. It also stalls one cycle on load-use hazards, flushes on taken branches and keeps a saturating stall counter.

## Interface
- MAX_WAIT, 15: the largest busy-cycle count still accepted; one more consecutive busy cycle halts the pipeline.
- CNT_W, 16: width of stall_count.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- instr_id  in  20  instruction in IF/ID.
- instr_ex  in  20  instruction in ID/EX.
- instr_mem  in  20  instruction in EX/MEM.
- branch_taken  in  1  EX-stage branch comparison result.
- mem_busy  in  1  data memory not ready this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads NOP (20'b0).
- id_ex_bubble  out  1  ID/EX loads NOP instead of ID contents.
- ex_mem_write  out  1  EX/MEM load enable.
- mem_wb_bubble  out  1  MEM/WB loads zeros.
- stall_count  out  CNT_W  saturating count of stall cycles.
- mem_timeout  out  1  sticky timeout flag.
- state  out  2  FSM state, for debug.

## Operation
- Instruction fields are op[19:16], rd[15:12], rs[11:8] and rt[7:4].
- Opcodes:
  - 0: NOP.
  - 1–4: ADD/SUB/AND/OR; read rs and rt, write rd.
  - 5: ADDI; reads rs, writes rd.
  - 6: LOAD; reads rs, writes rd.
  - 7: STORE; reads rs and rt.
  - 8: BEQ; reads rs and rt.
  - 9–15: treated as NOP.
- R0 never causes a hazard.
- freeze = mem_busy AND op(instr_mem) ∈ {LOAD, STORE}, evaluated in RUN or MEM_WAIT.
- load_use = op(instr_ex)==LOAD, rd(instr_ex)≠0, and rd matches any register read by instr_id.
- flush = op(instr_ex)==BEQ AND branch_taken.
- Priority is HALT > freeze > flush > load_use. A suppressed event reappears later because the registers hold it.
- Default outputs (no event): pc_write=1, if_id_write=1, ex_mem_write=1, all flush/bubble signals 0.
- freeze or HALT: pc_write=0, if_id_write=0, ex_mem_write=0, mem_wb_bubble=1, id_ex_bubble=0 (ID/EX holds).
- flush: if_id_flush=1, id_ex_bubble=1, pc_write=1.
- load_use: pc_write=0, if_id_write=0, id_ex_bubble=1.
- FSM states: RUN=0, MEM_WAIT=1, HALT=2; encoding 3 returns to RUN.
  - RUN with freeze: go to MEM_WAIT, wait_cnt←1.
  - MEM_WAIT with freeze: if wait_cnt==MAX_WAIT go to HALT and set mem_timeout←1; otherwise wait_cnt+1.
  - MEM_WAIT without freeze: go to RUN, wait_cnt←0.
  - HALT: left only by reset.
- stall_count increments on each cycle with freeze, load_use or HALT active; flush-only cycles do not count. It saturates at all ones.

## Timing
- Control outputs are combinational from the current state and inputs, so they act on the same rising edge. state, wait_cnt, stall_count and mem_timeout are registered.
- Reset values: state=RUN, wait_cnt=0, stall_count=0, mem_timeout=0. Outputs therefore take their default values during reset.
- Reset asserted mid-freeze or in HALT clears the state asynchronously. Outputs return to defaults in the same cycle.
- Exactly MAX_WAIT+1 consecutive freeze cycles cause HALT at the following edge; MAX_WAIT consecutive cycles do not.
- A load_use stall lasts exactly one cycle. After it, the LOAD sits in EX/MEM and forwarding from MEM/WB resolves the dependency.
- If freeze drops in the same cycle that wait_cnt==MAX_WAIT, the FSM returns to RUN with no timeout.

## Structure
- Shared package pipeline_pkg holds:
  - opcode constants;
  - field bit positions;
  - NOP encoding 20'b0;
  - state encoding.
- One combinational sub-module, instr_regs_used, returns per instruction: reads_rs, reads_rt, writes_rd, is_mem. It is instantiated for ID, EX and MEM.

## Test plan
- Load-use stall: instr_ex=LOAD rd=3, instr_id=ADD rs=3 → one cycle with pc_write=0, id_ex_bubble=1; stall_count 0→1. The same pair with rd=0 → no stall.
- Branch with load-use: instr_ex=BEQ, branch_taken=1, instr_id reading the same registers → if_id_flush=1, id_ex_bubble=1, pc_write=1; stall_count unchanged.
- Wait within limit: instr_mem=STORE, mem_busy high 15 cycles then low (MAX_WAIT=15) → 15 frozen cycles, then RUN; mem_timeout=0; stall_count=15.
- Timeout: same as above with mem_busy high 16 cycles → state=HALT and mem_timeout=1 after the 16th edge. The pipeline stays frozen after mem_busy drops.
- Reset in HALT: reset pulsed between edges → state=RUN, stall_count=0, mem_timeout=0 immediately.
- Saturation: CNT_W=4, 20 load_use cycles → stall_count holds at 15.
